poly_lift_stream: RTL and testbench

- Input-side counterpart of the NTT output reduction path; feeds the NTT multiplier.
- Accepts N_IN coefficients mod Q (Q = 2048/4096/8192, selected by poly_q), one per valid/ready beat.
- Lifts each coefficient to its centred representative, then maps it into [0, q-1] for q = 12587009.
- Zero-pads the stream to N_OUT coefficients, as the NTT input buffer expects.

---
 rtl/poly_lift_stream_pkg.sv | 19 +
 rtl/poly_lift_stream_coef_lift.sv | 40 ++++
 rtl/poly_lift_stream.sv | 175 +++++++++++++++++
 tb/tb_poly_lift_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_lift_stream_pkg.sv
// Shared constants and types for the poly_lift_stream coefficient lifter.
package poly_lift_stream_pkg;

  localparam logic [23:0] NTT_Q      = 24'd12587009;
  localparam logic [23:0] NTT_Q_HALF = 24'd6293504;

  localparam logic [1:0] Q_SEL_2048 = 2'b00;
  localparam logic [1:0] Q_SEL_4096 = 2'b01;
  localparam logic [1:0] Q_SEL_RSVD = 2'b10;
  localparam logic [1:0] Q_SEL_8192 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/poly_lift_stream_coef_lift.sv
// coef_lift: combinational centred lift of one coefficient mod Q into [0, NTT_Q-1],
// or trit decode when ternary is set.
module coef_lift
  import poly_lift_stream_pkg::*;
(
  input  logic [12:0] coef,
  input  logic [1:0]  poly_q,
  input  logic        ternary,
  output logic [23:0] lifted
);

  logic [1:0]  qsel;
  logic [23:0] v;
  logic [23:0] q_mod;
  logic [23:0] q_half;

  always_comb begin
    qsel = (poly_q == Q_SEL_RSVD) ? Q_SEL_4096 : poly_q;
    // Select code doubles as the mask for coefficient bits [12:11].
    v = {11'd0, coef[12:11] & qsel, coef[10:0]};
    case (qsel)
      Q_SEL_2048: q_mod = 24'd2048;
      Q_SEL_8192: q_mod = 24'd8192;
      default:    q_mod = 24'd4096;
    endcase
    q_half = q_mod >> 1;
    if (ternary) begin
      case (coef[1:0])
        2'b01:   lifted = 24'd1;
        2'b11:   lifted = NTT_Q - 24'd1;
        default: lifted = '0;
      endcase
    end else if (v >= q_half) begin
      lifted = v - q_mod + NTT_Q;
    end else begin
      lifted = v;
    end
  end

endmodule

// File: rtl/poly_lift_stream.sv
// poly_lift_stream: lifts N_IN mod-Q coefficients into Z_q and zero-pads to N_OUT beats.
// Optional trit input mode is compiled in with POLY_LIFT_TERNARY_EN.
module poly_lift_stream
  import poly_lift_stream_pkg::*;
#(
  parameter int unsigned N_IN  = 509,
  parameter int unsigned N_OUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  poly_q,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_coef,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_coef,
  output logic        busy,
`ifdef POLY_LIFT_TERNARY_EN
  input  logic        ternary,
  output logic        trit_err,
`endif
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(N_OUT + 1);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(N_OUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       qsel_q, qsel_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [23:0]      out_coef_q, out_coef_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic        reg_free;
  logic        out_fire;
  logic        start_acc;
  logic        in_fire;
  logic        tern_eff;
  logic [23:0] lifted;

  assign reg_free  = !out_valid_q || out_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign start_acc = (state_q == ST_IDLE) && start;
  assign in_ready  = (state_q == ST_LOAD) && reg_free;
  assign in_fire   = in_ready && in_valid;

`ifdef POLY_LIFT_TERNARY_EN
  logic tern_q, tern_d;
  logic terr_q, terr_d;

  always_comb begin
    tern_d = tern_q;
    terr_d = terr_q;
    if (start_acc) begin
      tern_d = ternary;
      terr_d = 1'b0;
    end else if (in_fire && tern_q && in_coef[1:0] == 2'b10) begin
      terr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tern_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      tern_q <= tern_d;
      terr_q <= terr_d;
    end
  end

  assign tern_eff = tern_q;
  assign trit_err = terr_q;
`else
  assign tern_eff = 1'b0;
`endif

  coef_lift u_coef_lift (
    .coef    (in_coef),
    .poly_q  (qsel_q),
    .ternary (tern_eff),
    .lifted  (lifted)
  );

  always_comb begin
    state_d     = state_q;
    qsel_d      = qsel_q;
    ld_cnt_d    = ld_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_cnt_d   = out_cnt_q + 1'b1;
    end

    // ld_cnt counts beats written into the output register (data then padding).
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          qsel_d    = poly_q;
          ld_cnt_d  = '0;
          out_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_coef_d  = lifted;
          ld_cnt_d    = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST_IN) begin
            state_d = (N_OUT > N_IN) ? ST_PAD : ST_FLUSH;
          end
        end
      end
      ST_PAD: begin
        if (reg_free) begin
          out_valid_d = 1'b1;
          out_coef_d  = '0;
          ld_cnt_d    = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST_OUT) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (out_fire && out_cnt_q == LAST_OUT) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      qsel_q      <= '0;
      ld_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qsel_q      <= qsel_d;
      ld_cnt_q    <= ld_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_poly_lift_stream.sv
// Directed, table-driven bench for poly_lift_stream (trit checks under POLY_LIFT_TERNARY_EN).
module tb_poly_lift_stream;

  localparam int unsigned N_IN  = 509;
  localparam int unsigned N_OUT = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  poly_q;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_coef;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_coef;
  logic        busy;
  logic        done;
`ifdef POLY_LIFT_TERNARY_EN
  logic        ternary;
  logic        trit_err;
`endif

  always #5 clk = ~clk;

  poly_lift_stream #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .poly_q    (poly_q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .busy      (busy),
`ifdef POLY_LIFT_TERNARY_EN
    .ternary   (ternary),
    .trit_err  (trit_err),
`endif
    .done      (done)
  );

  typedef struct {
    logic [1:0]  q;
    logic [12:0] coef;
    logic [23:0] exp;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [12:0] stim    [N_IN];
  logic [23:0] exp_out [N_OUT];
  logic [23:0] got     [N_OUT];

  int unsigned n_got, done_cnt, done_cyc, stall_errs, extra_acc;
  logic        busy_at0, busy_at_done, terr_at0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  function automatic logic [23:0] ref_lift(input logic [1:0] q, input logic [12:0] c);
    int unsigned m, v;
    m = (q == 2'b00) ? 2048 : (q == 2'b11) ? 8192 : 4096;
    v = int'(c) % m;
    if (v >= m / 2) return 24'(v + 12587009 - m);
    return 24'(v);
  endfunction

  task automatic build_expect(input logic [1:0] q);
    for (int i = 0; i < int'(N_OUT); i++)
      exp_out[i] = (i < int'(N_IN)) ? ref_lift(q, stim[i]) : 24'd0;
  endtask

  // Runs one frame: start at the next negedge, in_valid held high throughout.
  task automatic run_frame(input logic [1:0] q, input bit bp, input bit tern, input int abort_at);
    int unsigned idx;
    logic        prev_stall;
    logic [23:0] prev_coef;
    idx = 0; n_got = 0; done_cnt = 0; done_cyc = 0; stall_errs = 0; extra_acc = 0;
    prev_stall = 1'b0; prev_coef = '0; busy_at_done = 1'b1;
    for (int i = 0; i < int'(N_OUT); i++) got[i] = 'x;
    @(negedge clk);
    poly_q = q; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
`ifdef POLY_LIFT_TERNARY_EN
    ternary = tern;
`else
    if (tern) $display("note: ternary frame requested in a build without it");
`endif
    @(negedge clk);
    poly_q = ~q;
    for (int j = 0; j < 8000; j++) begin
      start     = (j == 100);
      in_valid  = 1'b1;
      in_coef   = (idx < N_IN) ? stim[idx] : 13'h1555;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (j == 0) begin
        busy_at0 = busy;
`ifdef POLY_LIFT_TERNARY_EN
        terr_at0 = trit_err;
`else
        terr_at0 = 1'b0;
`endif
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin done_cyc = j; busy_at_done = busy; end
      end
      if (prev_stall && (!out_valid || out_coef !== prev_coef)) stall_errs++;
      prev_stall = out_valid && !out_ready;
      prev_coef  = out_coef;
      if (out_valid && out_ready) begin
        if (n_got < N_OUT) got[n_got] = out_coef;
        n_got++;
      end
      if (in_valid && in_ready) begin
        if (idx >= N_IN) extra_acc++;
        else idx++;
        if (abort_at >= 0 && idx == abort_at) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          return;
        end
      end
      if (done_cnt > 0 && j >= int'(done_cyc) + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic verify_frame(input string name, input bit timed);
    int unsigned errs, first;
    errs = 0; first = 0;
    for (int i = 0; i < int'(N_OUT); i++)
      if (got[i] !== exp_out[i]) begin
        if (errs == 0) first = i;
        errs++;
      end
    if (errs != 0)
      $display("  %s first differing beat %0d: got %0d want %0d", name, first, got[first], exp_out[first]);
    check({name, " data errors"}, errs, 0);
    check({name, " beats out"}, n_got, N_OUT);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " stall changes"}, stall_errs, 0);
    check({name, " extra accepts"}, extra_acc, 0);
    check({name, " busy after start"}, 32'(busy_at0), 1);
    check({name, " busy at done"}, 32'(busy_at_done), 0);
    if (timed) check({name, " start-to-done cycles"}, done_cyc, 1025);
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{2'b00, 13'd0,    24'd0};
    vecs[1]  = '{2'b00, 13'd1023, 24'd1023};
    vecs[2]  = '{2'b00, 13'd1024, 24'd12585985};
    vecs[3]  = '{2'b00, 13'd2047, 24'd12587008};
    vecs[4]  = '{2'b00, 13'h1FFF, 24'd12587008};
    vecs[5]  = '{2'b01, 13'd2048, 24'd12584961};
    vecs[6]  = '{2'b11, 13'd4096, 24'd12582913};
    vecs[7]  = '{2'b10, 13'd2048, 24'd12584961};
    vecs[8]  = '{2'b01, 13'd4095, 24'd12587008};
    vecs[9]  = '{2'b11, 13'd8191, 24'd12587008};
    vecs[10] = '{2'b11, 13'd4095, 24'd4095};
    vecs[11] = '{2'b01, 13'h1800, 24'd12584961};

    rst_n = 1'b0; start = 1'b0; poly_q = '0; in_valid = 1'b1; in_coef = '0; out_ready = 1'b1;
`ifdef POLY_LIFT_TERNARY_EN
    ternary = 1'b0;
`endif
    #12;
    check("reset in_ready", 32'(in_ready), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_coef", 32'(out_coef), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle in_ready with in_valid", 32'(in_ready), 0);
    check("idle busy", 32'(busy), 0);

    for (int k = 0; k < 12; k++) begin
      stim[0] = vecs[k].coef;
      for (int i = 1; i < int'(N_IN); i++) stim[i] = 13'($urandom);
      run_frame(vecs[k].q, 1'b0, 1'b0, -1);
      check($sformatf("vec%0d first output", k), 32'(got[0]), 32'(vecs[k].exp));
      build_expect(vecs[k].q);
      verify_frame($sformatf("vec%0d frame", k), 1'b1);
    end

    for (int i = 0; i < int'(N_IN); i++) stim[i] = 13'($urandom);
    build_expect(2'b11);
    run_frame(2'b11, 1'b1, 1'b0, -1);
    verify_frame("backpressure", 1'b0);

    for (int i = 0; i < int'(N_IN); i++) stim[i] = 13'(i * 37 + 5);
    run_frame(2'b01, 1'b0, 1'b0, 200);
    #1;
    check("abort done pulses", done_cnt, 0);
    check("abort out_valid", 32'(out_valid), 0);
    check("abort busy", 32'(busy), 0);
    check("abort in_ready", 32'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    build_expect(2'b01);
    run_frame(2'b01, 1'b0, 1'b0, -1);
    verify_frame("after abort", 1'b1);

`ifdef POLY_LIFT_TERNARY_EN
    for (int i = 0; i < int'(N_IN); i++) stim[i] = '0;
    stim[0] = 13'h0001; stim[1] = 13'h1FFF; stim[2] = 13'h1FFC; stim[3] = 13'h0002;
    for (int i = 0; i < int'(N_OUT); i++) exp_out[i] = '0;
    exp_out[0] = 24'd1; exp_out[1] = 24'd12587008;
    run_frame(2'b00, 1'b0, 1'b1, -1);
    verify_frame("ternary", 1'b1);
    check("ternary trit_err at start", 32'(terr_at0), 0);
    check("ternary trit_err sticky", 32'(trit_err), 1);
    for (int i = 0; i < int'(N_IN); i++) stim[i] = 13'($urandom);
    build_expect(2'b00);
    run_frame(2'b00, 1'b0, 1'b0, -1);
    check("trit_err cleared on start", 32'(terr_at0), 0);
    verify_frame("post ternary", 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
